// File: rtl/core_types_pkg.sv
// Core-wide PRF geometry and the pending-read slot payload.
package core_types_pkg;

   localparam int unsigned PRF_BANK_COUNT     = 4;
   localparam int unsigned LOG_PRF_BANK_COUNT = 2;
   localparam int unsigned LOG_PR_COUNT       = 7;

   typedef struct packed {
      logic                    valid;
      logic [LOG_PR_COUNT-1:0] pr;
   } prf_read_slot_t;

endpackage

// File: rtl/prf_read_req_arbiter_pkg.sv
// Helpers for splitting a physical register index into bank and in-bank row.
package prf_read_req_arbiter_pkg;

   import core_types_pkg::*;

   function automatic logic [LOG_PRF_BANK_COUNT-1:0] pr_bank(input logic [LOG_PR_COUNT-1:0] pr);
      return pr[LOG_PRF_BANK_COUNT-1:0];
   endfunction

   function automatic logic [LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] pr_upper(input logic [LOG_PR_COUNT-1:0] pr);
      return pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
   endfunction

endpackage

// File: rtl/prf_read_req_arbiter_rr.sv
// Combinational round-robin pick: first requesting index at or after ptr, with wrap.
module rr_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned LOG_WIDTH = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]     req,
   input  logic [LOG_WIDTH-1:0] ptr,
   output logic [WIDTH-1:0]     grant,
   output logic [LOG_WIDTH-1:0] grant_index,
   output logic                 grant_valid
);

   localparam int unsigned IW = LOG_WIDTH + 1;

   logic [IW-1:0] idx;

   // Scan upward from ptr, keeping only the first hit
   always_comb begin
      grant       = '0;
      grant_index = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         idx = IW'(ptr) + IW'(i);
         if (idx >= IW'(WIDTH)) begin
            idx = idx - IW'(WIDTH);
         end
         if (!grant_valid && req[LOG_WIDTH'(idx)]) begin
            grant_valid                = 1'b1;
            grant_index                = LOG_WIDTH'(idx);
            grant[LOG_WIDTH'(idx)]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prf_read_req_arbiter.sv
// Shares the banked PRF read ports among issue queues: one pending slot per
// operand, one round-robin grant per bank per cycle, same-cycle refill ready.
module prf_read_req_arbiter
   import core_types_pkg::*;
   import prf_read_req_arbiter_pkg::*;
#(
   parameter int unsigned REQ_COUNT     = 4,
   parameter int unsigned LOG_REQ_COUNT = $clog2(REQ_COUNT)
) (
   input  logic                                                     CLK,
   input  logic                                                     nRST,
   input  logic [REQ_COUNT-1:0]                                     req_A_valid,
   input  logic [REQ_COUNT-1:0][LOG_PR_COUNT-1:0]                   req_A_PR,
   input  logic [REQ_COUNT-1:0]                                     req_B_valid,
   input  logic [REQ_COUNT-1:0][LOG_PR_COUNT-1:0]                   req_B_PR,
   output logic [REQ_COUNT-1:0]                                     req_ready,
   output logic [PRF_BANK_COUNT-1:0]                                bank_read_valid,
   output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] bank_read_upper_PR,
   output logic [PRF_BANK_COUNT-1:0][LOG_REQ_COUNT-1:0]             bank_read_req_id,
   output logic [PRF_BANK_COUNT-1:0]                                bank_read_is_B
);

   localparam int unsigned SLOT_COUNT     = 2 * REQ_COUNT;
   localparam int unsigned LOG_SLOT_COUNT = $clog2(SLOT_COUNT);

   prf_read_slot_t [SLOT_COUNT-1:0]                          slot_q;
   logic [PRF_BANK_COUNT-1:0][LOG_SLOT_COUNT-1:0]            ptr_q;
   logic [PRF_BANK_COUNT-1:0][SLOT_COUNT-1:0]                bank_req;
   logic [PRF_BANK_COUNT-1:0][SLOT_COUNT-1:0]                bank_grant;
   logic [PRF_BANK_COUNT-1:0][LOG_SLOT_COUNT-1:0]            grant_index;
   logic [PRF_BANK_COUNT-1:0]                                grant_valid;
   logic [SLOT_COUNT-1:0]                                    granted;

   // Candidate mask per bank: valid slots whose PR lives in that bank
   always_comb begin
      bank_req = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         for (int s = 0; s < SLOT_COUNT; s++) begin
            bank_req[b][s] = slot_q[s].valid &&
                             (pr_bank(slot_q[s].pr) == LOG_PRF_BANK_COUNT'(b));
         end
      end
   end

   for (genvar gb = 0; gb < PRF_BANK_COUNT; gb++) begin : g_bank
      rr_arbiter #(
         .WIDTH      (SLOT_COUNT),
         .LOG_WIDTH  (LOG_SLOT_COUNT)
      ) u_rr (
         .req         (bank_req[gb]),
         .ptr         (ptr_q[gb]),
         .grant       (bank_grant[gb]),
         .grant_index (grant_index[gb]),
         .grant_valid (grant_valid[gb])
      );
   end

   // Union of all bank grants; a slot maps to exactly one bank
   always_comb begin
      granted = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         granted = granted | bank_grant[b];
      end
   end

   // Steer the granted slot of each bank onto its read port
   always_comb begin
      bank_read_valid    = '0;
      bank_read_upper_PR = '0;
      bank_read_req_id   = '0;
      bank_read_is_B     = '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
         if (grant_valid[b]) begin
            bank_read_valid[b]    = 1'b1;
            bank_read_upper_PR[b] = pr_upper(slot_q[grant_index[b]].pr);
            bank_read_req_id[b]   = LOG_REQ_COUNT'(grant_index[b] >> 1);
            bank_read_is_B[b]     = grant_index[b][0];
         end
      end
   end

   // A requester is ready once both of its slots are empty or leaving this cycle
   always_comb begin
      req_ready = '0;
      for (int r = 0; r < REQ_COUNT; r++) begin
         req_ready[r] = (!slot_q[2*r].valid   || granted[2*r]) &&
                        (!slot_q[2*r+1].valid || granted[2*r+1]);
      end
   end

   // Slot refill/retire and per-bank round-robin pointer advance
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         slot_q <= '0;
         ptr_q  <= '0;
      end else begin
         for (int r = 0; r < REQ_COUNT; r++) begin
            if (req_ready[r]) begin
               slot_q[2*r]   <= prf_read_slot_t'{valid: req_A_valid[r], pr: req_A_PR[r]};
               slot_q[2*r+1] <= prf_read_slot_t'{valid: req_B_valid[r], pr: req_B_PR[r]};
            end else begin
               if (granted[2*r]) begin
                  slot_q[2*r].valid <= 1'b0;
               end
               if (granted[2*r+1]) begin
                  slot_q[2*r+1].valid <= 1'b0;
               end
            end
         end
         for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (grant_valid[b]) begin
               if (grant_index[b] == LOG_SLOT_COUNT'(SLOT_COUNT - 1)) begin
                  ptr_q[b] <= '0;
               end else begin
                  ptr_q[b] <= grant_index[b] + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/prf_read_req_arbiter.md
Name: prf_read_req_arbiter

Overview:
- Shares the banked PRF read ports among REQ_COUNT issue queues (ALU IQs and others), each issuing up to two operand reads (A, B) per cycle.
- Each requester's accepted reads are latched into one pending slot per operand.
- Each bank grants at most one pending read per cycle, round-robin across all 2*REQ_COUNT slots.
- Requesters are backpressured through req_ready, which feeds the issuing IQ's pipeline_ready.

Parameters:
- REQ_COUNT, 4, number of requesting issue queues.
- LOG_REQ_COUNT, $clog2(REQ_COUNT), requester index width.
- PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT: taken from core_types_pkg (defaults 4, 2, 7).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- req_A_valid  in  [REQ_COUNT]  operand A read request per requester
- req_A_PR  in  [REQ_COUNT][LOG_PR_COUNT]  operand A physical reg
- req_B_valid  in  [REQ_COUNT]  operand B read request per requester
- req_B_PR  in  [REQ_COUNT][LOG_PR_COUNT]  operand B physical reg
- req_ready  out  [REQ_COUNT]  requester may present new reads this cycle
- bank_read_valid  out  [PRF_BANK_COUNT]  read issued on bank
- bank_read_upper_PR  out  [PRF_BANK_COUNT][LOG_PR_COUNT-LOG_PRF_BANK_COUNT]  PR index within bank
- bank_read_req_id  out  [PRF_BANK_COUNT][LOG_REQ_COUNT]  granted requester
- bank_read_is_B  out  [PRF_BANK_COUNT]  1 = operand B, 0 = operand A

Behaviour:
- Reset: all pending slots invalid, all bank RR pointers = 0. Outputs: bank_read_valid=0, req_ready all 1, other outputs 0.
- Slot numbering: slot s = 2*r + (is_B). Each slot holds valid, PR.
- Slot bank = PR[LOG_PRF_BANK_COUNT-1:0].
- Arbitration (combinational from registered slots and pointers):
  - For each bank b, candidates are the valid slots whose bank = b.
  - Grant the first candidate at or after ptr[b], scanning upward with wrap.
  - At most one grant per bank per cycle; a slot matches exactly one bank, so it is never granted twice.
- Outputs for bank b with a grant: bank_read_valid=1, upper_PR=PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT], req_id=s>>1, is_B=s[0]. With no grant, all outputs for bank b are 0.
- Pointer update: on a grant for bank b, ptr[b] <= granted slot + 1, wrapping at 2*REQ_COUNT. With no grant, ptr[b] holds.
- req_ready[r] = (slot 2r invalid or granted this cycle) AND (slot 2r+1 invalid or granted this cycle). This is a same-cycle refill path.
- Acceptance:
  - If req_ready[r], slot 2r <= {req_A_valid[r], req_A_PR[r]} and slot 2r+1 <= {req_B_valid[r], req_B_PR[r]}.
  - Otherwise, granted slots of r clear and ungranted slots hold.
  - Requests with valid=0 while ready=1 leave the slot invalid.
  - Requests presented while req_ready=0 are ignored. Requesters must not present them: the IQ holds issue via pipeline_ready.
- Latency: minimum 1 cycle, request accepted to bank_read_valid.
- Same-bank conflicts (e.g. A and B of one requester on the same bank):
  - Serialized over consecutive cycles in RR order.
  - The requester stays not-ready until both slots are granted or emptied.
- Full throughput case: one requester whose reads hit distinct banks gets both granted the cycle after acceptance and sustains 1 issue/cycle.
- Fairness: every valid slot is granted within 2*REQ_COUNT cycles of becoming valid.
- Async reset mid-operation: pending reads are discarded and pointers return to 0; no bank_read_valid in the reset-release cycle.

Decomposition:
- core_types_pkg: PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT. Add typedef prf_read_slot_t {valid, PR}.
- One natural sub-module: rr_arbiter (params WIDTH; inputs req[WIDTH], ptr; outputs one-hot grant, grant_index, grant_valid). Purely combinational; instantiate one per bank.
- The top level holds slots, pointers, ready logic and bank steering.

Test Plan:
- Reset then idle: req_ready=4'b1111, bank_read_valid=0 for 5 cycles, pointers 0.
- Requester 0 presents A_PR=7'h05 (bank 1) and B_PR=7'h0A (bank 2):
  - Next cycle: bank1 valid, upper_PR=1, req_id=0, is_B=0; bank2 valid, upper_PR=2, req_id=0, is_B=1.
  - req_ready[0] stays 1.
- Requester 2 presents A_PR=7'h04 and B_PR=7'h08 (both bank 0):
  - Cycle+1: bank0 grants slot 4 (A); req_ready[2]=0.
  - Cycle+2: bank0 grants slot 5 (B); req_ready[2]=1.
- All 4 requesters request A on bank 3, with PRs 7'h03, 7'h07, 7'h0B, 7'h0F:
  - Grants req_id 0,1,2,3 on consecutive cycles; ptr[3]=7 afterwards.
  - Each requester becomes ready in the cycle its grant occurs.
- Requester 1 holds slot 2 (bank 0) and requester 0 re-requests bank 0 every cycle with ptr[0]=1: requester 1 is granted within 2 cycles, proving no starvation.
- Assert nRST low while 3 slots are pending: bank_read_valid=0 immediately, and after release req_ready=4'b1111 with no stale reads issued.
